// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter.
// The optional watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        ACK
    } arb_state_t;

    localparam int BYTE_W          = 8;
    localparam int DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last winner
// and wraps, using a double-width rotate followed by a priority encoder.
module uart_arb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NR       = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W-1:0]   start;
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    always_comb begin
        start = (last == LAST_IDX) ? '0 : last + 1'b1;
        // rot[0] is the requester at 'start', rot[1] the next one, and so on
        rot   = NUM_REQ'({req, req} >> start);
        off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum    = {1'b0, start} + {1'b0, off};
        winner = (sum >= NR) ? IDX_W'(sum - NR) : IDX_W'(sum);
        valid  = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to build the per-byte watchdog that releases a hung grant.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_n,
    input  logic [NUM_REQ-1:0]          i_Req,
    input  logic [BYTE_W*NUM_REQ-1:0]   i_Req_Byte,
    output logic [NUM_REQ-1:0]          o_Ack,
    output logic                        o_TX_DV,
    output logic [BYTE_W-1:0]           o_TX_Byte,
    input  logic                        i_TX_Done,
    output logic                        o_Busy,
    output logic [$clog2(NUM_REQ)-1:0]  o_Owner,
    output logic                        o_Timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t       state;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int               WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            r_timeout;

    assign o_Timeout = r_timeout;
`else
    assign o_Timeout = 1'b0;
`endif

    uart_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (i_Req),
        .last   (r_last),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    assign o_Busy = (state != IDLE);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= IDLE;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= '0;
            o_Ack     <= '0;
            o_Owner   <= '0;
            r_last    <= IDX_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            // DV, Ack and Timeout are single-cycle pulses
            o_TX_DV <= 1'b0;
            o_Ack   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        o_Owner   <= pick_idx;
                        o_TX_Byte <= i_Req_Byte[BYTE_W*pick_idx +: BYTE_W];
                        o_TX_DV   <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT_DONE: begin
                    if (i_TX_Done) begin
                        o_Ack <= NUM_REQ'(1) << o_Owner;
                        state <= ACK;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (wd_cnt == WD_MAX) begin
                        o_Ack     <= NUM_REQ'(1) << o_Owner;
                        r_timeout <= 1'b1;
                        state     <= ACK;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                ACK: begin
                    r_last <= o_Owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
